// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, reserved-op range and datapath width.
// Imported by the ALU, the decoder and the ALU share arbiter.
package alu_pkg;

    localparam int XLEN = 32;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SLTU = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
    localparam logic [3:0] OP_ABJ  = 4'b1010;
    localparam logic [3:0] OP_NOP  = 4'b1111;

    localparam logic [3:0] OP_RSV_LO = 4'b1011;
    localparam logic [3:0] OP_RSV_HI = 4'b1110;

    function automatic logic [3:0] op_sanitize(input logic [3:0] op);
        return (op >= OP_RSV_LO && op <= OP_RSV_HI) ? OP_NOP : op;
    endfunction

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// Combinational ALU shared by the arbiter.
// NOP (and anything unknown) yields a zero result.
module alu_share_arbiter_alu #(
    parameter int XLEN = alu_pkg::XLEN
) (
    input  logic [XLEN-1:0] src_A,
    input  logic [XLEN-1:0] src_B,
    input  logic [3:0]      alu_op,
    output logic [XLEN-1:0] alu_result,
    output logic            zero
);
    import alu_pkg::*;

    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0] shamt;

    assign shamt = src_B[SHW-1:0];

    always_comb begin
        alu_result = '0;
        unique case (alu_op)
            OP_ADD:  alu_result = src_A + src_B;
            OP_SUB:  alu_result = src_A - src_B;
            OP_AND:  alu_result = src_A & src_B;
            OP_OR:   alu_result = src_A | src_B;
            OP_XOR:  alu_result = src_A ^ src_B;
            OP_SLT:  alu_result = XLEN'($signed(src_A) < $signed(src_B));
            OP_SLTU: alu_result = XLEN'(src_A < src_B);
            OP_SLL:  alu_result = src_A << shamt;
            OP_SRL:  alu_result = src_A >> shamt;
            OP_SRA:  alu_result = $unsigned($signed(src_A) >>> shamt);
            OP_ABJ:  alu_result = src_A & ~src_B;
            default: alu_result = '0;
        endcase
    end

    assign zero = (alu_result == '0);

endmodule

// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter around one shared ALU with a registered result.
// Define ALU_ARB_RR_EN for round-robin ties; otherwise requester 0 wins.
module alu_share_arbiter #(
    parameter int XLEN = alu_pkg::XLEN,
    parameter int ID_W = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [XLEN-1:0] req0_src_A,
    input  logic [XLEN-1:0] req0_src_B,
    input  logic [3:0]      req0_alu_op,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [XLEN-1:0] req1_src_A,
    input  logic [XLEN-1:0] req1_src_B,
    input  logic [3:0]      req1_alu_op,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_result,
    output logic            rsp_zero,
    output logic [ID_W-1:0] rsp_id
);
    import alu_pkg::*;

    logic            slot_free;
    logic            grant0;
    logic            grant1;
    logic            xfer;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] alu_result;
    logic            alu_zero;

    assign slot_free = !rsp_valid || rsp_ready;

`ifdef ALU_ARB_RR_EN
    logic prio;

    assign grant1 = req1_valid && (!req0_valid || prio);

    // The requester just served loses the next tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prio <= 1'b0;
        end else if (xfer) begin
            prio <= !grant1;
        end
    end
`else
    assign grant1 = req1_valid && !req0_valid;
`endif

    assign grant0     = req0_valid && !grant1;
    assign req0_ready = grant0 && slot_free;
    assign req1_ready = grant1 && slot_free;
    assign xfer       = (req0_valid && req0_ready) ||
                        (req1_valid && req1_ready);

    // Idle ALU inputs park at zero/NOP so the datapath does not toggle.
    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = OP_NOP;
        unique case (1'b1)
            grant0: begin
                alu_a  = req0_src_A;
                alu_b  = req0_src_B;
                alu_op = op_sanitize(req0_alu_op);
            end
            grant1: begin
                alu_a  = req1_src_A;
                alu_b  = req1_src_B;
                alu_op = op_sanitize(req1_alu_op);
            end
            default: ;
        endcase
    end

    alu_share_arbiter_alu #(
        .XLEN(XLEN)
    ) u_alu (
        .src_A     (alu_a),
        .src_B     (alu_b),
        .alu_op    (alu_op),
        .alu_result(alu_result),
        .zero      (alu_zero)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_id     <= '0;
        end else if (xfer) begin
            rsp_valid  <= 1'b1;
            rsp_result <= alu_result;
            rsp_zero   <= alu_zero;
            rsp_id     <= ID_W'(grant1);
        end else if (rsp_ready) begin
            rsp_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter.
// Honours ALU_ARB_RR_EN for the expected tie order.
module tb_alu_share_arbiter;

    localparam int XL = 32;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req0_valid, req0_ready;
    logic          req1_valid, req1_ready;
    logic [XL-1:0] req0_src_A, req0_src_B;
    logic [XL-1:0] req1_src_A, req1_src_B;
    logic [3:0]    req0_alu_op, req1_alu_op;
    logic          rsp_valid, rsp_ready, rsp_zero;
    logic [XL-1:0] rsp_result;
    logic [0:0]    rsp_id;

    typedef struct packed {
        logic [XL-1:0] res;
        logic          z;
        logic          id;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.XLEN(XL), .ID_W(1)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_src_A (req0_src_A),
        .req0_src_B (req0_src_B),
        .req0_alu_op(req0_alu_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_src_A (req1_src_A),
        .req1_src_B (req1_src_B),
        .req1_alu_op(req1_alu_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_id     (rsp_id)
    );

    function automatic exp_t model(input logic [3:0] op, input logic [XL-1:0] a,
                                   input logic [XL-1:0] b, input logic id);
        exp_t       e;
        logic [3:0] o;
        o = op;
        if (op >= 4'd11 && op <= 4'd14) o = 4'hF;
        case (o)
            4'd0:    e.res = a + b;
            4'd1:    e.res = a - b;
            4'd2:    e.res = a & b;
            4'd3:    e.res = a | b;
            4'd4:    e.res = a ^ b;
            4'd5:    e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6:    e.res = (a < b) ? 32'd1 : 32'd0;
            4'd7:    e.res = a << b[4:0];
            4'd8:    e.res = a >> b[4:0];
            4'd9:    e.res = $unsigned($signed(a) >>> b[4:0]);
            4'd10:   e.res = a & ~b;
            default: e.res = '0;
        endcase
        e.z  = (e.res == '0);
        e.id = id;
        return e;
    endfunction

    // An empty scoreboard yields X so the following comparison fails.
    function automatic exp_t next_exp();
        exp_t e;
        e = 'x;
        if (sb.size() != 0) e = sb.pop_front();
        return e;
    endfunction

    task automatic drive0(input logic v, input logic [3:0] op,
                          input logic [XL-1:0] a, input logic [XL-1:0] b);
        req0_valid = v; req0_alu_op = op; req0_src_A = a; req0_src_B = b;
    endtask

    task automatic drive1(input logic v, input logic [3:0] op,
                          input logic [XL-1:0] a, input logic [XL-1:0] b);
        req1_valid = v; req1_alu_op = op; req1_src_A = a; req1_src_B = b;
    endtask

    task automatic idle();
        drive0(1'b0, 4'h0, '0, '0);
        drive1(1'b0, 4'h0, '0, '0);
    endtask

    task automatic tick();
        #1;
        if (req0_valid && req0_ready)
            sb.push_back(model(req0_alu_op, req0_src_A, req0_src_B, 1'b0));
        if (req1_valid && req1_ready)
            sb.push_back(model(req1_alu_op, req1_src_A, req1_src_B, 1'b1));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        #2;
        n_chk++;
        if ({rsp_valid, rsp_id, rsp_zero, rsp_result, req0_ready, req1_ready} !== '0)
            $display("FAIL reset_state got v=%b id=%b z=%b r=%h rdy=%b%b want all 0",
                     rsp_valid, rsp_id, rsp_zero, rsp_result, req0_ready, req1_ready);
        else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_tie();
        exp_t       e;
        logic [3:0] ids;
`ifdef ALU_ARB_RR_EN
        ids = 4'b1010;
`else
        ids = 4'b0000;
`endif
        rsp_ready = 1'b1;
        drive0(1'b1, 4'h4, 32'hFFFFFFFF, 32'h0F0F0F0F);
        drive1(1'b1, 4'h2, 32'hF0F0F0F0, 32'h0F0F0F0F);
        for (int i = 0; i < 4; i++) begin
            tick();
            e = next_exp();
            n_chk++;
            if ({rsp_valid, rsp_id, rsp_zero, rsp_result} !== {1'b1, e.id, e.z, e.res}
                || rsp_id !== ids[i]
                || rsp_result !== (ids[i] ? 32'h0 : 32'hF0F0F0F0))
                $display("FAIL tie[%0d] got v=%b id=%b z=%b r=%h want id=%b z=%b r=%h",
                         i, rsp_valid, rsp_id, rsp_zero, rsp_result, ids[i], e.z, e.res);
            else n_pass++;
        end
        idle();
        tick();
    endtask

    task automatic test_add_sub();
        exp_t e;
        rsp_ready = 1'b1;
        drive0(1'b1, 4'h0, 32'd1000, 32'd2000);
        tick();
        e = next_exp();
        n_chk++;
        if ({rsp_valid, rsp_id, rsp_zero, rsp_result} !== {1'b1, e.id, e.z, e.res}
            || rsp_result !== 32'd3000)
            $display("FAIL add got v=%b id=%b z=%b r=%0d want v=1 id=0 z=0 r=3000",
                     rsp_valid, rsp_id, rsp_zero, rsp_result);
        else n_pass++;
        drive0(1'b1, 4'h1, 32'd30, 32'd30);
        tick();
        e = next_exp();
        n_chk++;
        if ({rsp_valid, rsp_id, rsp_zero, rsp_result} !== {1'b1, e.id, e.z, e.res}
            || rsp_zero !== 1'b1)
            $display("FAIL sub got v=%b id=%b z=%b r=%0d want v=1 id=0 z=1 r=0",
                     rsp_valid, rsp_id, rsp_zero, rsp_result);
        else n_pass++;
        idle();
        tick();
        n_chk++;
        if (rsp_valid !== 1'b0 || rsp_result !== 32'd0 || rsp_zero !== 1'b1)
            $display("FAIL drain got v=%b z=%b r=%h want v=0 z=1 r=0 held",
                     rsp_valid, rsp_zero, rsp_result);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        exp_t          e;
        logic [3:0]    op [6] = '{4'h9, 4'h8, 4'h7, 4'h3, 4'h5, 4'h1};
        logic [XL-1:0] a  [6] = '{32'h80000000, 32'h80000000, 32'h1,
                                  32'h0F, 32'hFFFFFFFF, 32'h0};
        logic [XL-1:0] b  [6] = '{32'd4, 32'd4, 32'd31, 32'hF0, 32'h0, 32'h1};
        logic [XL-1:0] r  [6] = '{32'hF8000000, 32'h08000000, 32'h80000000,
                                  32'hFF, 32'h1, 32'hFFFFFFFF};
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive0(1'b1, op[i], a[i], b[i]);
            tick();
            e = next_exp();
            n_chk++;
            if ({rsp_valid, rsp_id, rsp_zero, rsp_result} !== {1'b1, e.id, e.z, e.res}
                || rsp_result !== r[i])
                $display("FAIL b2b[%0d] got v=%b id=%b r=%h want v=1 id=0 r=%h",
                         i, rsp_valid, rsp_id, rsp_result, r[i]);
            else n_pass++;
        end
        idle();
        tick();
    endtask

    task automatic test_backpressure();
        exp_t e;
        rsp_ready = 1'b1;
        drive1(1'b1, 4'h6, 32'hF0000000, 32'hF0000001);
        tick();
        e = next_exp();
        drive1(1'b0, 4'h0, '0, '0);
        drive0(1'b1, 4'hA, 32'hFFFFFFFF, 32'h0FF00FF0);
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_chk++;
            if ({rsp_valid, rsp_id, rsp_zero, rsp_result} !== {1'b1, e.id, e.z, e.res}
                || rsp_result !== 32'd1 || rsp_id !== 1'b1
                || req0_ready !== 1'b0 || req1_ready !== 1'b0)
                $display("FAIL bp_hold[%0d] got v=%b id=%b r=%h rdy=%b%b want v=1 id=1 r=1 rdy=00",
                         i, rsp_valid, rsp_id, rsp_result, req0_ready, req1_ready);
            else n_pass++;
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        n_chk++;
        if (req0_ready !== 1'b1)
            $display("FAIL bp_release got req0_ready=%b want 1", req0_ready);
        else n_pass++;
        tick();
        e = next_exp();
        n_chk++;
        if ({rsp_valid, rsp_id, rsp_zero, rsp_result} !== {1'b1, e.id, e.z, e.res}
            || rsp_result !== 32'hF00FF00F || rsp_id !== 1'b0)
            $display("FAIL bp_abj got v=%b id=%b r=%h want v=1 id=0 r=f00ff00f",
                     rsp_valid, rsp_id, rsp_result);
        else n_pass++;
        idle();
        tick();
    endtask

    task automatic test_reserved();
        exp_t       e;
        logic [3:0] op;
        rsp_ready = 1'b1;
        for (int c = 11; c <= 14; c++) begin
            op = 4'(c);
            drive0(1'b1, op, 32'd5, 32'd7);
            #1;
            n_chk++;
            if (dut.alu_op !== 4'hF || req0_ready !== 1'b1)
                $display("FAIL rsv_op[%0d] got alu_op=%h ready=%b want f 1",
                         c, dut.alu_op, req0_ready);
            else n_pass++;
            tick();
            e = next_exp();
            n_chk++;
            if ({rsp_valid, rsp_id, rsp_zero, rsp_result} !== {1'b1, e.id, e.z, e.res})
                $display("FAIL rsv_res[%0d] got v=%b z=%b r=%h want v=1 z=%b r=%h",
                         c, rsp_valid, rsp_zero, rsp_result, e.z, e.res);
            else n_pass++;
        end
        idle();
        tick();
    endtask

    task automatic test_slt();
        exp_t e;
        rsp_ready = 1'b1;
        drive1(1'b1, 4'h5, 32'h00000000, 32'hF0000001);
        tick();
        e = next_exp();
        n_chk++;
        if ({rsp_valid, rsp_id, rsp_zero, rsp_result} !== {1'b1, e.id, e.z, e.res}
            || rsp_result !== 32'd0 || rsp_zero !== 1'b1)
            $display("FAIL slt got v=%b id=%b z=%b r=%h want v=1 id=1 z=1 r=0",
                     rsp_valid, rsp_id, rsp_zero, rsp_result);
        else n_pass++;
        idle();
        tick();
    endtask

    task automatic test_reset_mid();
        exp_t e;
        rsp_ready = 1'b0;
        drive1(1'b1, 4'h0, 32'd5, 32'd6);
        tick();
        e = next_exp();
        n_chk++;
        if ({rsp_valid, rsp_id, rsp_zero, rsp_result} !== {1'b1, e.id, e.z, e.res})
            $display("FAIL pre_reset got v=%b id=%b r=%h want v=1 id=1 r=%h",
                     rsp_valid, rsp_id, rsp_result, e.res);
        else n_pass++;
        idle();
        #2;
        reset_n = 1'b0;
        #1;
        n_chk++;
        if ({rsp_valid, rsp_id, rsp_zero, rsp_result, req0_ready, req1_ready} !== '0)
            $display("FAIL async_reset got v=%b id=%b z=%b r=%h rdy=%b%b want all 0",
                     rsp_valid, rsp_id, rsp_zero, rsp_result, req0_ready, req1_ready);
        else n_pass++;
        sb.delete();
        @(negedge clk);
        reset_n   = 1'b1;
        rsp_ready = 1'b1;
        drive0(1'b1, 4'h0, 32'd7, 32'd8);
        drive1(1'b1, 4'h1, 32'd9, 32'd1);
        #1;
        n_chk++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0)
            $display("FAIL post_reset_tie got rdy=%b%b want 10", req0_ready, req1_ready);
        else n_pass++;
        tick();
        e = next_exp();
        n_chk++;
        if ({rsp_valid, rsp_id, rsp_zero, rsp_result} !== {1'b1, e.id, e.z, e.res}
            || rsp_id !== 1'b0 || rsp_result !== 32'd15)
            $display("FAIL post_reset_rsp got v=%b id=%b r=%h want v=1 id=0 r=f",
                     rsp_valid, rsp_id, rsp_result);
        else n_pass++;
        idle();
        tick();
    endtask

    initial begin
        reset_n   = 1'b0;
        rsp_ready = 1'b1;
        idle();
        test_reset();
        test_tie();
        test_add_sub();
        test_back_to_back();
        test_backpressure();
        test_reserved();
        test_slt();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
